// File: rtl/arranque_pkg.sv
// Shared types and helpers for the soft-start ramp controller.
package arranque_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SUBIR = 2'd1,
      PLENA = 2'd2,
      BAJAR = 2'd3
   } estado_t;

   // Duty for level k out of n_steps: floor(k * (2^duty_w - 1) / n_steps).
   // The 64-bit intermediate keeps the product exact for any practical width.
   function automatic logic [63:0] duty_nivel(input int unsigned k,
                                              input int unsigned n_steps,
                                              input int unsigned duty_w);
      logic [63:0] lleno;
      lleno = (64'd1 << duty_w) - 64'd1;
      return (64'(k) * lleno) / 64'(n_steps);
   endfunction

endpackage

// File: rtl/rampa_temporizador.sv
// Dwell down-counter: load, count down to zero, report terminal count.
module rampa_temporizador #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               zero
);

   logic [DWELL_W-1:0] cnt;

   // Counter register; clear beats load, load beats decrement, holds at zero.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - DWELL_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/arranque_rampa_param.sv
// Stepped soft-start ramp controller.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | level 0, waiting for a run request
//   SUBIR | ramping up one level per dwell period
//   PLENA | at full level N_STEPS, holding while requested
//   BAJAR | ramping down one level per slow dwell period
module arranque_rampa_param
   import arranque_pkg::*;
#(
   parameter int N_STEPS    = 3,
   parameter int DUTY_W     = 8,
   parameter int DWELL_W    = 16,
   parameter int DWELL_FAST = 100,
   parameter int DWELL_SLOW = 1000,
   localparam int KW        = $clog2(N_STEPS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Rapido,
   input  logic              Lento,
   input  logic              paro,
   output logic [KW-1:0]     nivel,
   output logic [DUTY_W-1:0] duty,
   output logic              en_rampa,
   output logic              a_plena
);

   localparam logic [DWELL_W-1:0] RECARGA_RAPIDA = DWELL_W'(DWELL_FAST - 1);
   localparam logic [DWELL_W-1:0] RECARGA_LENTA  = DWELL_W'(DWELL_SLOW - 1);
   localparam logic [KW-1:0]      K_MAX          = KW'(N_STEPS);

   estado_t            estado, est_nxt;
   logic [KW-1:0]      k_nxt;
   logic               req;
   logic               tmr_clr, tmr_load, tmr_zero;
   logic [DWELL_W-1:0] tmr_val, recarga_subir;

   assign req           = Rapido | Lento;
   assign recarga_subir = Rapido ? RECARGA_RAPIDA : RECARGA_LENTA;

   rampa_temporizador #(
      .DWELL_W (DWELL_W)
   ) u_temporizador (
      .clk      (clk),
      .reset    (reset),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Next state, next level and dwell timer commands; paro overrides everything.
   always_comb begin
      est_nxt  = estado;
      k_nxt    = nivel;
      tmr_clr  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = recarga_subir;
      if (paro) begin
         est_nxt = IDLE;
         k_nxt   = '0;
         tmr_clr = 1'b1;
      end else begin
         case (estado)
            IDLE: begin
               if (req) begin
                  k_nxt    = KW'(1);
                  est_nxt  = (N_STEPS == 1) ? PLENA : SUBIR;
                  tmr_load = 1'b1;
               end else begin
                  tmr_clr  = 1'b1;
               end
            end
            SUBIR: begin
               if (!req) begin
                  est_nxt  = BAJAR;
                  tmr_load = 1'b1;
                  tmr_val  = RECARGA_LENTA;
               end else if (tmr_zero) begin
                  k_nxt    = nivel + KW'(1);
                  tmr_load = 1'b1;
                  if (nivel + KW'(1) == K_MAX)
                     est_nxt = PLENA;
               end
            end
            PLENA: begin
               if (!req) begin
                  est_nxt  = BAJAR;
                  tmr_load = 1'b1;
                  tmr_val  = RECARGA_LENTA;
               end
            end
            BAJAR: begin
               if (req) begin
                  // Resume climbing from the current level; if the descent has
                  // not left full level yet there is nothing to climb.
                  est_nxt  = (nivel == K_MAX) ? PLENA : SUBIR;
                  tmr_load = 1'b1;
               end else if (tmr_zero) begin
                  k_nxt = nivel - KW'(1);
                  if (nivel == KW'(1)) begin
                     est_nxt = IDLE;
                     tmr_clr = 1'b1;
                  end else begin
                     tmr_load = 1'b1;
                     tmr_val  = RECARGA_LENTA;
                  end
               end
            end
            default: begin
               est_nxt = IDLE;
               k_nxt   = '0;
               tmr_clr = 1'b1;
            end
         endcase
      end
   end

   // State, level and all outputs registered together so they always agree.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= IDLE;
         nivel    <= '0;
         duty     <= '0;
         en_rampa <= 1'b0;
         a_plena  <= 1'b0;
      end else begin
         estado   <= est_nxt;
         nivel    <= k_nxt;
         duty     <= DUTY_W'(duty_nivel(32'(k_nxt), N_STEPS, DUTY_W));
         en_rampa <= (est_nxt == SUBIR) || (est_nxt == BAJAR);
         a_plena  <= (est_nxt == PLENA);
      end
   end

endmodule

// File: tb/tb_arranque_rampa_param.sv
// Bench for the soft-start ramp: directed scenarios plus a random run,
// all checked every cycle against an abstract behavioural model.
module tb_arranque_rampa_param;

   localparam int N   = 3;
   localparam int DW  = 8;
   localparam int DF  = 2;
   localparam int DS  = 4;
   localparam int KW  = $clog2(N + 1);

   localparam int M_REST = 0;
   localparam int M_UP   = 1;
   localparam int M_FULL = 2;
   localparam int M_DOWN = 3;

   logic          clk = 1'b0;
   logic          reset, Rapido, Lento, paro;
   logic [KW-1:0] nivel;
   logic [DW-1:0] duty;
   logic          en_rampa, a_plena;

   int checks   = 0;
   int failures = 0;

   // Model: operating mode, current level, cycles left before next level change.
   int m_mode = M_REST;
   int m_lvl  = 0;
   int m_left = 0;

   arranque_rampa_param #(
      .N_STEPS    (N),
      .DUTY_W     (DW),
      .DWELL_W    (16),
      .DWELL_FAST (DF),
      .DWELL_SLOW (DS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Rapido   (Rapido),
      .Lento    (Lento),
      .paro     (paro),
      .nivel    (nivel),
      .duty     (duty),
      .en_rampa (en_rampa),
      .a_plena  (a_plena)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic l, input logic p, input logic rs);
      bit req;
      int d;
      req = r | l;
      d   = r ? DF : DS;
      if (rs || p) begin
         m_mode = M_REST; m_lvl = 0; m_left = 0;
      end else begin
         case (m_mode)
            M_REST: if (req) begin
               m_lvl  = 1;
               m_left = d;
               m_mode = (m_lvl == N) ? M_FULL : M_UP;
            end
            M_UP: if (!req) begin
               m_mode = M_DOWN; m_left = DS;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_lvl++;
                  m_left = d;
                  if (m_lvl == N) m_mode = M_FULL;
               end
            end
            M_FULL: if (!req) begin
               m_mode = M_DOWN; m_left = DS;
            end
            default: if (req) begin
               m_mode = (m_lvl == N) ? M_FULL : M_UP;
               m_left = d;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_lvl--;
                  m_left = DS;
                  if (m_lvl == 0) m_mode = M_REST;
               end
            end
         endcase
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
   task automatic cyc(input logic r, input logic l, input logic p, input logic rs);
      Rapido = r; Lento = l; paro = p; reset = rs;
      @(posedge clk);
      model_step(r, l, p, rs);
      #1;
      chk("model_nivel",    32'(nivel),    32'(m_lvl));
      chk("model_duty",     32'(duty),     32'((m_lvl * 255) / N));
      chk("model_en_rampa", 32'(en_rampa), 32'((m_mode == M_UP) || (m_mode == M_DOWN)));
      chk("model_a_plena",  32'(a_plena),  32'(m_mode == M_FULL));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rapido = 0; Lento = 0; paro = 0; reset = 1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("reset_nivel", 32'(nivel), 0);
      chk("reset_duty", 32'(duty), 0);
      chk("reset_flags", 32'({en_rampa, a_plena}), 0);

      // Fast ramp from idle: levels at edges 0/2/4.
      for (int e = 0; e <= 4; e++) begin
         cyc(1, 0, 0, 0);
         if (e == 0) begin chk("fast_e0_nivel", 32'(nivel), 1); chk("fast_e0_duty", 32'(duty), 85); end
         if (e == 1) chk("fast_e1_nivel", 32'(nivel), 1);
         if (e == 2) begin chk("fast_e2_nivel", 32'(nivel), 2); chk("fast_e2_duty", 32'(duty), 170); end
         if (e == 4) begin
            chk("fast_e4_nivel", 32'(nivel), 3);
            chk("fast_e4_duty", 32'(duty), 255);
            chk("fast_e4_plena", 32'(a_plena), 1);
         end
      end
      cyc(0, 0, 0, 1);

      // Slow ramp up, release at edge 10, descend to idle by edge 22.
      for (int e = 0; e <= 23; e++) begin
         cyc(0, e < 10, 0, 0);
         if (e == 3)  chk("slow_e3_nivel", 32'(nivel), 1);
         if (e == 4)  chk("slow_e4_nivel", 32'(nivel), 2);
         if (e == 8)  chk("slow_e8_nivel", 32'(nivel), 3);
         if (e == 10) chk("slow_e10_enr", 32'(en_rampa), 1);
         if (e == 13) chk("slow_e13_nivel", 32'(nivel), 3);
         if (e == 14) chk("slow_e14_nivel", 32'(nivel), 2);
         if (e == 18) chk("slow_e18_nivel", 32'(nivel), 1);
         if (e == 22) begin
            chk("slow_e22_nivel", 32'(nivel), 0);
            chk("slow_e22_duty", 32'(duty), 0);
            chk("slow_e22_enr", 32'(en_rampa), 0);
         end
      end

      // Slow ramp, fast request joins at level 1.
      for (int e = 0; e <= 7; e++) begin
         cyc(e >= 1, 1, 0, 0);
         if (e == 3) chk("mix_e3_nivel", 32'(nivel), 1);
         if (e == 4) chk("mix_e4_nivel", 32'(nivel), 2);
         if (e == 5) chk("mix_e5_nivel", 32'(nivel), 2);
         if (e == 6) chk("mix_e6_nivel", 32'(nivel), 3);
      end
      cyc(0, 0, 0, 1);

      // Descend from full to level 2, then resume climbing.
      for (int e = 0; e <= 19; e++) begin
         cyc(0, (e < 9) || (e >= 14), 0, 0);
         if (e == 13) chk("resume_e13_nivel", 32'(nivel), 2);
         if (e == 14) chk("resume_e14_enr", 32'(en_rampa), 1);
         if (e == 17) chk("resume_e17_nivel", 32'(nivel), 2);
         if (e == 18) chk("resume_e18_nivel", 32'(nivel), 3);
      end
      cyc(0, 0, 0, 1);

      // Emergency stop at level 2, request held during stop.
      for (int e = 0; e <= 6; e++) begin
         cyc(1, 0, e >= 3, 0);
         if (e == 2) chk("paro_e2_nivel", 32'(nivel), 2);
         if (e == 3) begin
            chk("paro_e3_nivel", 32'(nivel), 0);
            chk("paro_e3_duty", 32'(duty), 0);
            chk("paro_e3_enr", 32'(en_rampa), 0);
         end
         if (e == 6) chk("paro_e6_nivel", 32'(nivel), 0);
      end
      cyc(0, 0, 0, 0);

      // Reset while at full level, reset with request, then release.
      for (int e = 0; e <= 8; e++) begin
         cyc(1, 0, 0, (e >= 5) && (e <= 7));
         if (e == 4) chk("rst_e4_plena", 32'(a_plena), 1);
         if (e == 5) chk("rst_e5_all", 32'({nivel, duty, en_rampa, a_plena}), 0);
         if (e == 7) chk("rst_e7_nivel", 32'(nivel), 0);
         if (e == 8) chk("rst_e8_nivel", 32'(nivel), 1);
      end

      // Random run with held requests and occasional stop/reset.
      begin
         logic r, l;
         r = 0; l = 0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 12) r = ~r;
            if ($urandom_range(0, 99) < 12) l = ~l;
            cyc(r, l, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
